peak_detector: RTL and testbench

PEAK_DETECTOR -- requirements
Module: peak_detector

---
 rtl/peak_detector_if.sv | 32 +++
 rtl/peak_detector.sv | 140 ++++++++++++++
 tb/tb_peak_detector.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/peak_detector_if.sv
// Bus bundle for peak_detector: sample/config inputs and pulse measurement results.
interface peak_detector_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TIME_W = 12,
  parameter int unsigned HOLD_W = 8
);
  logic signed [DATA_W-1:0] input_data;
  logic signed [DATA_W-1:0] threshold;
  logic        [HOLD_W-1:0] holdoff;
  logic signed [DATA_W-1:0] peak_amplitude;
  logic        [TIME_W-1:0] peak_time;
  logic        [TIME_W-1:0] pulse_width;
  logic                     peak_valid;
  logic                     width_ovf;
  logic                     busy;
  logic        [15:0]       event_count;
  logic        [15:0]       reject_count;

  // Source of samples/configuration, consumer of results.
  modport master (
    output input_data, threshold, holdoff,
    input  peak_amplitude, peak_time, pulse_width, peak_valid, width_ovf, busy,
           event_count, reject_count
  );

  // The detector itself.
  modport slave (
    input  input_data, threshold, holdoff,
    output peak_amplitude, peak_time, pulse_width, peak_valid, width_ovf, busy,
           event_count, reject_count
  );
endinterface

// File: rtl/peak_detector.sv
// Threshold-crossing peak detector: measures maximum, time-to-maximum and width of each
// above-threshold pulse, with a programmable dead-time after every pulse end.
module peak_detector #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TIME_W = 12,
  parameter int unsigned HOLD_W = 8
) (
  input logic            clk,
  input logic            reset,
  peak_detector_if.slave bus
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAbove   = 2'd1;
  localparam logic [1:0] StHoldoff = 2'd2;

  localparam logic [TIME_W-1:0] TimeMax = '1;

  logic        [1:0]        r_state;
  logic signed [DATA_W-1:0] r_max;
  logic        [TIME_W-1:0] r_peak_cnt;
  logic        [TIME_W-1:0] r_width_cnt;
  logic        [TIME_W-1:0] r_time_cnt;
  logic                     r_ovf;
  logic        [HOLD_W-1:0] r_hold_cnt;
  logic                     r_prev_above;

  logic signed [DATA_W-1:0] r_peak_amplitude;
  logic        [TIME_W-1:0] r_peak_time;
  logic        [TIME_W-1:0] r_pulse_width;
  logic                     r_peak_valid;
  logic                     r_width_ovf;
  logic        [15:0]       r_event_count;
  logic        [15:0]       r_reject_count;

  logic                     w_above;
  logic                     w_crossing;
  logic                     w_new_max;
  logic                     w_width_sat;
  logic                     w_time_sat;
  logic        [TIME_W-1:0] w_width_nx;
  logic        [TIME_W-1:0] w_time_nx;

  // Detection compares and saturating counter increments.
  always_comb begin
    w_above     = $signed(bus.input_data) > $signed(bus.threshold);
    w_crossing  = w_above & ~r_prev_above;
    w_new_max   = $signed(bus.input_data) > r_max;
    w_width_sat = (r_width_cnt == TimeMax);
    w_time_sat  = (r_time_cnt == TimeMax);
    w_width_nx  = w_width_sat ? r_width_cnt : r_width_cnt + TIME_W'(1);
    w_time_nx   = w_time_sat ? r_time_cnt : r_time_cnt + TIME_W'(1);
  end

  // Pulse FSM, measurement counters and result registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= StIdle;
      r_max            <= '0;
      r_peak_cnt       <= '0;
      r_width_cnt      <= '0;
      r_time_cnt       <= '0;
      r_ovf            <= 1'b0;
      r_hold_cnt       <= '0;
      r_prev_above     <= 1'b0;
      r_peak_amplitude <= '0;
      r_peak_time      <= '0;
      r_pulse_width    <= '0;
      r_peak_valid     <= 1'b0;
      r_width_ovf      <= 1'b0;
      r_event_count    <= '0;
      r_reject_count   <= '0;
    end else begin
      r_peak_valid <= 1'b0;
      r_prev_above <= w_above;
      unique case (r_state)
        StIdle: begin
          if (w_above) begin
            r_state     <= StAbove;
            r_max       <= bus.input_data;
            r_peak_cnt  <= '0;
            r_width_cnt <= TIME_W'(1);
            r_time_cnt  <= '0;
            r_ovf       <= 1'b0;
          end
        end
        StAbove: begin
          if (w_above) begin
            r_width_cnt <= w_width_nx;
            r_time_cnt  <= w_time_nx;
            // Sticky: any counter that had to stop counting marks the pulse as overlong.
            if (w_width_sat || w_time_sat) begin
              r_ovf <= 1'b1;
            end
            // Strict compare so ties keep the earliest maximum.
            if (w_new_max) begin
              r_max      <= bus.input_data;
              r_peak_cnt <= w_time_nx;
            end
          end else begin
            r_peak_amplitude <= r_max;
            r_peak_time      <= r_peak_cnt;
            r_pulse_width    <= r_width_cnt;
            r_width_ovf      <= r_ovf;
            r_peak_valid     <= 1'b1;
            r_event_count    <= r_event_count + 16'd1;
            if (bus.holdoff != '0) begin
              r_hold_cnt <= bus.holdoff - HOLD_W'(1);
              r_state    <= StHoldoff;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        StHoldoff: begin
          // Only a fresh rising crossing counts, so a long rejected pulse counts once.
          if (w_crossing) begin
            r_reject_count <= r_reject_count + 16'd1;
          end
          if (r_hold_cnt == '0) begin
            r_state <= StIdle;
          end else begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.peak_amplitude = r_peak_amplitude;
  assign bus.peak_time      = r_peak_time;
  assign bus.pulse_width    = r_pulse_width;
  assign bus.peak_valid     = r_peak_valid;
  assign bus.width_ovf      = r_width_ovf;
  assign bus.busy           = (r_state == StAbove) || (r_state == StHoldoff);
  assign bus.event_count    = r_event_count;
  assign bus.reject_count   = r_reject_count;

endmodule

// File: tb/tb_peak_detector.sv
// Bench for peak_detector: two instances (TIME_W 12 and 4) share one directed stimulus
// stream; a pulse-level model predicts every output each cycle.
module tb_peak_detector;
  localparam int DW   = 16;
  localparam int TW_A = 12;
  localparam int TW_B = 4;
  localparam int HW   = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  peak_detector_if #(.DATA_W(DW), .TIME_W(TW_A), .HOLD_W(HW)) bus_a ();
  peak_detector_if #(.DATA_W(DW), .TIME_W(TW_B), .HOLD_W(HW)) bus_b ();

  peak_detector #(.DATA_W(DW), .TIME_W(TW_A), .HOLD_W(HW)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  peak_detector #(.DATA_W(DW), .TIME_W(TW_B), .HOLD_W(HW)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, $signed(act), act, $signed(exp), exp, $time);
    end
  endtask

  // ---------------- model: works on whole pulses held in a queue ----------------
  int tmax [2] = '{4095, 15};
  int m_q[$];
  int m_mode;   // 0 idle, 1 in pulse, 2 dead-time
  int m_hold;
  bit m_prev;
  int e_amp;
  int e_pt [2];
  int e_w [2];
  bit e_ovf [2];
  bit e_valid;
  bit e_busy;
  bit [15:0] e_ev;
  bit [15:0] e_rej;
  int d_s, th_s, mx, ix, n;
  bit ab;

  always @(posedge clk) begin
    d_s  = int'(bus_a.input_data);
    th_s = int'(bus_a.threshold);
    ab   = d_s > th_s;
    if (reset) begin
      m_q.delete();
      m_mode  = 0;
      m_hold  = 0;
      m_prev  = 1'b0;
      e_amp   = 0;
      e_valid = 1'b0;
      e_ev    = '0;
      e_rej   = '0;
      for (int k = 0; k < 2; k++) begin
        e_pt[k]  = 0;
        e_w[k]   = 0;
        e_ovf[k] = 1'b0;
      end
    end else begin
      e_valid = 1'b0;
      case (m_mode)
        0: if (ab) begin
          m_q.delete();
          m_q.push_back(d_s);
          m_mode = 1;
        end
        1: if (ab) begin
          m_q.push_back(d_s);
        end else begin
          n  = m_q.size();
          mx = m_q[0];
          ix = 0;
          for (int i = 1; i < n; i++) if (m_q[i] > mx) begin mx = m_q[i]; ix = i; end
          e_amp = mx;
          for (int k = 0; k < 2; k++) begin
            e_w[k]   = (n > tmax[k]) ? tmax[k] : n;
            e_pt[k]  = (ix > tmax[k]) ? tmax[k] : ix;
            e_ovf[k] = n > tmax[k];
          end
          e_valid = 1'b1;
          e_ev    = e_ev + 16'd1;
          if (int'(bus_a.holdoff) > 0) begin
            m_hold = int'(bus_a.holdoff) - 1;
            m_mode = 2;
          end else begin
            m_mode = 0;
          end
        end
        default: begin
          if (ab && !m_prev) e_rej = e_rej + 16'd1;
          if (m_hold == 0) m_mode = 0;
          else m_hold--;
        end
      endcase
      m_prev = ab;
    end
    e_busy = (m_mode != 0);
  end

  // ---------------- per-cycle compare, away from the active edge ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_valid", bus_a.peak_valid, e_valid);
      check("a_amp", bus_a.peak_amplitude, e_amp);
      check("a_ptime", bus_a.peak_time, e_pt[0]);
      check("a_width", bus_a.pulse_width, e_w[0]);
      check("a_ovf", bus_a.width_ovf, e_ovf[0]);
      check("a_busy", bus_a.busy, e_busy);
      check("a_evcnt", bus_a.event_count, e_ev);
      check("a_rejcnt", bus_a.reject_count, e_rej);
      check("b_valid", bus_b.peak_valid, e_valid);
      check("b_amp", bus_b.peak_amplitude, e_amp);
      check("b_ptime", bus_b.peak_time, e_pt[1]);
      check("b_width", bus_b.pulse_width, e_w[1]);
      check("b_ovf", bus_b.width_ovf, e_ovf[1]);
      check("b_busy", bus_b.busy, e_busy);
      check("b_evcnt", bus_b.event_count, e_ev);
      check("b_rejcnt", bus_b.reject_count, e_rej);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cfg(input int thr, input int hold);
    bus_a.threshold = 16'(thr);
    bus_b.threshold = 16'(thr);
    bus_a.holdoff   = 8'(hold);
    bus_b.holdoff   = 8'(hold);
  endtask

  task automatic step(input int d);
    bus_a.input_data = 16'(d);
    bus_b.input_data = 16'(d);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int s030 [4] = '{50, 120, 300, 250};
    int s031 [3] = '{150, 150, 120};
    int s032 [5] = '{50, 200, 50, 200, 50};

    reset = 1'b1;
    cfg(0, 0);
    bus_a.input_data = '0;
    bus_b.input_data = '0;
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    step(0);
    check("rst_amp", bus_a.peak_amplitude, 0);
    check("rst_evcnt", bus_a.event_count, 0);
    check("rst_busy", bus_a.busy, 0);
    reset = 1'b0;
    step(0);

    // Basic pulse, no dead-time.
    cfg(100, 0);
    foreach (s030[i]) step(s030[i]);
    step(90);
    check("m030_valid", e_valid, 1);
    check("m030_amp", e_amp, 300);
    check("m030_ptime", e_pt[0], 1);
    check("m030_width", e_w[0], 3);
    check("m030_evcnt", e_ev, 1);
    check("d030_amp", bus_a.peak_amplitude, 300);
    step(0);
    step(0);

    // Tie keeps the first maximum.
    foreach (s031[i]) step(s031[i]);
    step(80);
    check("m031_amp", e_amp, 150);
    check("m031_ptime", e_pt[0], 0);
    check("m031_width", e_w[0], 3);
    step(0);

    // Dead-time rejects two crossings.
    cfg(100, 4);
    step(150);
    foreach (s032[i]) step(s032[i]);
    check("m032_rejcnt", e_rej, 2);
    check("m032_evcnt", e_ev, 3);
    check("d032_busy", bus_a.busy, 0);
    check("d032_rejcnt", bus_a.reject_count, 2);
    step(0);

    // Signed threshold and samples.
    cfg(-50, 0);
    step(-10);
    step(-60);
    check("m033_amp", e_amp, -10);
    check("m033_width", e_w[0], 1);
    check("d033_amp_hex", bus_a.peak_amplitude, 64'hFFFF_FFFF_FFFF_FFF6);
    step(-60);

    // Long pulse: saturation on the narrow instance only.
    cfg(0, 0);
    for (int i = 1; i <= 20; i++) step(i * 10);
    step(0);
    check("m034_width_b", e_w[1], 15);
    check("m034_ovf_b", e_ovf[1], 1);
    check("m034_ptime_b", e_pt[1], 15);
    check("m034_width_a", e_w[0], 20);
    check("m034_ptime_a", e_pt[0], 19);
    check("d034_ovf_b", bus_b.width_ovf, 1);
    step(0);

    // Sample equal to threshold is not above; threshold raised mid-pulse ends it.
    cfg(100, 0);
    step(100);
    check("eq_thr_busy", bus_a.busy, 0);
    step(150);
    cfg(200, 0);
    step(180);
    check("thr_chg_valid", e_valid, 1);
    check("thr_chg_amp", e_amp, 150);
    step(0);

    // Reset in the middle of a pulse discards it.
    cfg(100, 0);
    step(200);
    step(300);
    reset = 1'b1;
    step(400);
    reset = 1'b0;
    check("m035_valid", e_valid, 0);
    check("d035_amp", bus_a.peak_amplitude, 0);
    check("d035_evcnt", bus_a.event_count, 0);
    step(0);
    step(150);
    step(250);
    step(50);
    check("m035_amp", e_amp, 250);
    check("m035_ptime", e_pt[0], 1);
    check("m035_width", e_w[0], 2);
    check("m035_evcnt", e_ev, 1);
    step(0);
    step(0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
